// File: rtl/jtcontra_gfx_pkg.sv
// Shared definitions for the contra graphics ROM arbitration logic.
// Requester slot indices and the arbiter state encoding.
package jtcontra_gfx_pkg;

   localparam int OBJ  = 0;
   localparam int SCRA = 1;
   localparam int SCRB = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/jtcontra_rr_pick.sv
// One-hot round-robin picker: the prio requester wins outright, otherwise the
// first active requester found searching upward from ptr (wrapping, prio skipped).
module jtcontra_rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic [IW-1:0] prio,
   output logic [N-1:0]  win
);

   int   p;
   int   idx;
   logic found;

   always_comb begin
      win   = '0;
      found = 1'b0;
      p     = int'(prio);
      idx   = 0;
      for (int j = 0; j < N; j++) begin
         if (j == p && req[j]) begin
            win[j] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         for (int j = 0; j < N; j++) begin
            if (!found && j == idx && j != p && req[j]) begin
               win[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/jtcontra_gfx_rom_arb.sv
// Shares one graphics ROM SDRAM slot between the obj engine and both tile layers.
// One grant at a time; data and ok are routed back to the granted requester only.
//
// state | meaning
// IDLE  | no transfer; pick a winner as soon as any cs is high
// ISSUE | address just presented to the slot; rom_ok is stale and ignored
// WAIT  | waiting for rom_ok; handles withdrawal and address changes
// DONE  | req_ok pulse visible; grant released at the end of the cycle
module jtcontra_gfx_rom_arb
   import jtcontra_gfx_pkg::*;
#(
   parameter int N    = 3,
   parameter int AW   = 18,
   parameter int DW   = 16,
   parameter int PRIO = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_cs,
   input  logic [N*AW-1:0] req_addr,
   output logic [N-1:0]    req_ok,
   output logic [DW-1:0]   req_data,
   output logic            rom_cs,
   output logic [AW-1:0]   rom_addr,
   input  logic            rom_ok,
   input  logic [DW-1:0]   rom_data,
   output logic [N-1:0]    gnt
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] PTR_RST  = (N > 1) ? IW'(1) : '0;
   localparam logic [IW-1:0] PRIO_IDX = IW'(PRIO);

   arb_state_e    state_q, state_d;
   logic          rom_cs_q, rom_cs_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [N-1:0]  req_ok_q, req_ok_d;
   logic [DW-1:0] req_data_q, req_data_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] ptr_q, ptr_d;

   logic [N-1:0]  win;
   logic [AW-1:0] w_addr;
   logic [AW-1:0] g_addr;
   logic          g_cs;
   logic [IW-1:0] ptr_win;
   int            nxt;

   jtcontra_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req  (req_cs),
      .ptr  (ptr_q),
      .prio (PRIO_IDX),
      .win  (win)
   );

   // Pointer moves past the winner, never landing on the prio slot.
   always_comb begin
      w_addr  = '0;
      g_addr  = '0;
      ptr_win = ptr_q;
      nxt     = 0;
      for (int j = 0; j < N; j++) begin
         if (win[j]) w_addr = req_addr[j*AW +: AW];
         if (gnt_q[j]) g_addr = req_addr[j*AW +: AW];
         if (win[j] && j != PRIO) begin
            nxt = j + 1;
            if (nxt >= N) nxt = 0;
            if (nxt == PRIO) nxt = nxt + 1;
            if (nxt >= N) nxt = 0;
            ptr_win = IW'(nxt);
         end
      end
      g_cs = |(req_cs & gnt_q);
   end

   always_comb begin
      state_d    = state_q;
      rom_cs_d   = rom_cs_q;
      rom_addr_d = rom_addr_q;
      req_ok_d   = req_ok_q;
      req_data_d = req_data_q;
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_cs) begin
               rom_cs_d   = 1'b1;
               rom_addr_d = w_addr;
               gnt_d      = win;
               ptr_d      = ptr_win;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!g_cs) begin
               rom_cs_d = 1'b0;
               gnt_d    = '0;
               state_d  = ST_IDLE;
            end else if (g_addr != rom_addr_q) begin
               rom_addr_d = g_addr;
               state_d    = ST_ISSUE;
            end else if (rom_ok) begin
               req_data_d = rom_data;
               req_ok_d   = gnt_q;
               rom_cs_d   = 1'b0;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            req_ok_d = '0;
            gnt_d    = '0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
         req_ok_q   <= '0;
         req_data_q <= '0;
         gnt_q      <= '0;
         ptr_q      <= PTR_RST;
      end else begin
         state_q    <= state_d;
         rom_cs_q   <= rom_cs_d;
         rom_addr_q <= rom_addr_d;
         req_ok_q   <= req_ok_d;
         req_data_q <= req_data_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
      end
   end

   assign rom_cs   = rom_cs_q;
   assign rom_addr = rom_addr_q;
   assign req_ok   = req_ok_q;
   assign req_data = req_data_q;
   assign gnt      = gnt_q;

endmodule

// File: tb/tb_jtcontra_gfx_rom_arb.sv
// Scoreboard bench for the graphics ROM arbiter: directed requests, SDRAM slot
// model with programmable latency, monitor pops expectations on every req_ok.
module tb_jtcontra_gfx_rom_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  cs;
   logic [17:0] a [3];
   logic [53:0] req_addr;
   logic [2:0]  req_ok;
   logic [15:0] req_data;
   logic        rom_cs;
   logic [17:0] rom_addr;
   logic        rom_ok;
   logic [15:0] rom_data;
   logic [2:0]  gnt;

   assign req_addr = {a[2], a[1], a[0]};

   jtcontra_gfx_rom_arb #(.N(3), .AW(18), .DW(16), .PRIO(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_cs   (cs),
      .req_addr (req_addr),
      .req_ok   (req_ok),
      .req_data (req_data),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_ok   (rom_ok),
      .rom_data (rom_data),
      .gnt      (gnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [17:0] addr;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   logic [17:0] pend[3][$];
   int          tests = 0;
   int          fails = 0;
   bit          auto_en;
   bit          stale;
   int          lat;
   logic        prev_cs;
   logic [17:0] prev_addr;
   int          cnt;

   function automatic logic [15:0] data_of(input logic [17:0] ad);
      return {ad[15:8] ^ 8'hC3, ad[7:0] ^ 8'hA5} ^ {14'd0, ad[17:16]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // SDRAM slot model plus auto-mode requesters; drives inputs 1 time unit after the edge.
   initial begin
      prev_cs   = 1'b0;
      prev_addr = '0;
      cnt       = 0;
      rom_ok    = 1'b0;
      rom_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rom_cs && prev_cs && rom_addr == prev_addr) cnt++;
         else cnt = 0;
         rom_ok    = stale ? 1'b1 : (rom_cs && cnt >= lat);
         rom_data  = rom_ok ? data_of(rom_addr) : 16'hDEAD;
         prev_cs   = rom_cs;
         prev_addr = rom_addr;
         if (auto_en) begin
            for (int i = 0; i < 3; i++) begin
               if (req_ok[i] && cs[i]) begin
                  void'(pend[i].pop_front());
                  if (pend[i].size() > 0) a[i] = pend[i][0];
                  else cs[i] = 1'b0;
               end else if (!cs[i] && pend[i].size() > 0) begin
                  cs[i] = 1'b1;
                  a[i]  = pend[i][0];
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && req_ok != 3'b000) begin
            check("ok_onehot_granted", 32'($onehot(req_ok) && ((req_ok & ~gnt) == 3'b000)), 32'd1);
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL ok_unexpected: got req_ok=%b, expected none", req_ok);
            end else begin
               e = sbq.pop_front();
               check("ok_idx", 32'(req_ok), 32'd1 << e.idx);
               check("ok_addr", 32'(rom_addr), 32'(e.addr));
               check("ok_data", 32'(req_data), 32'(data_of(e.addr)));
            end
         end
      end
   end

   task automatic wait_rom_cs(input string name);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rom_cs && k < 50);
      check(name, 32'(rom_cs), 32'd1);
   endtask

   task automatic wait_ok_drop(input int i, input string name);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!req_ok[i] && k < 50);
      check(name, 32'(req_ok[i]), 32'd1);
      cs[i] = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while ((sbq.size() != 0 || pend[0].size() != 0 || pend[1].size() != 0 ||
              pend[2].size() != 0 || cs != 3'b000 || rom_cs) && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      cs      = 3'b000;
      a       = '{default: '0};
      auto_en = 1'b0;
      stale   = 1'b0;
      lat     = 2;
      repeat (3) @(negedge clk);
      check("rst_rom_cs", 32'(rom_cs), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_req_ok", 32'(req_ok), 32'd0);
      check("rst_req_data", 32'(req_data), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // single obj request
      auto_en = 1'b1;
      sbq.push_back('{0, 18'h01234});
      pend[0].push_back(18'h01234);
      wait_rom_cs("t1_rom_cs");
      check("t1_rom_addr", 32'(rom_addr), 32'h01234);
      check("t1_gnt", 32'(gnt), 32'h1);
      wait_drain("t1_drain");

      // tiles A and B compete: strict alternation
      sbq.push_back('{1, 18'h00100});
      sbq.push_back('{2, 18'h00200});
      sbq.push_back('{1, 18'h00101});
      sbq.push_back('{2, 18'h00201});
      pend[1].push_back(18'h00100);
      pend[1].push_back(18'h00101);
      pend[2].push_back(18'h00200);
      pend[2].push_back(18'h00201);
      wait_drain("t2_drain");

      // obj beats tile A arriving in the same cycle
      sbq.push_back('{0, 18'h00300});
      sbq.push_back('{1, 18'h00310});
      pend[0].push_back(18'h00300);
      pend[1].push_back(18'h00310);
      wait_drain("t3_drain");

      // stale rom_ok during ISSUE must be ignored
      auto_en = 1'b0;
      stale   = 1'b1;
      sbq.push_back('{2, 18'h00400});
      a[2]  = 18'h00400;
      cs[2] = 1'b1;
      wait_rom_cs("t4_rom_cs");
      check("t4_issue_no_ok", 32'(req_ok), 32'd0);
      @(negedge clk);
      check("t4_wait_no_ok", 32'(req_ok), 32'd0);
      @(negedge clk);
      check("t4_ok_latency", 32'(req_ok), 32'h4);
      cs[2] = 1'b0;
      stale = 1'b0;
      wait_drain("t4_drain");

      // address change in WAIT re-issues
      lat = 2;
      sbq.push_back('{2, 18'h00011});
      a[2]  = 18'h00010;
      cs[2] = 1'b1;
      wait_rom_cs("t5_rom_cs");
      @(negedge clk);
      a[2] = 18'h00011;
      @(negedge clk);
      check("t5_relatch_addr", 32'(rom_addr), 32'h00011);
      check("t5_relatch_cs", 32'(rom_cs), 32'd1);
      wait_ok_drop(2, "t5_ok");
      wait_drain("t5_drain");

      // withdrawal in WAIT
      lat   = 8;
      a[1]  = 18'h00500;
      cs[1] = 1'b1;
      wait_rom_cs("t6a_rom_cs");
      @(negedge clk);
      cs[1] = 1'b0;
      @(negedge clk);
      check("t6a_rom_cs", 32'(rom_cs), 32'd0);
      check("t6a_gnt", 32'(gnt), 32'd0);
      repeat (12) @(negedge clk);
      check("t6a_data_hold", 32'(req_data), 32'(data_of(18'h00011)));

      // reset in WAIT
      a[2]  = 18'h00600;
      cs[2] = 1'b1;
      wait_rom_cs("t6b_rom_cs");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6b_rom_cs", 32'(rom_cs), 32'd0);
      check("t6b_gnt", 32'(gnt), 32'd0);
      check("t6b_req_ok", 32'(req_ok), 32'd0);
      check("t6b_req_data", 32'(req_data), 32'd0);
      check("t6b_rom_addr", 32'(rom_addr), 32'd0);
      cs[2] = 1'b0;
      rst   = 1'b0;
      repeat (12) @(negedge clk);
      check("t6b_idle", 32'(rom_cs), 32'd0);
      check("sb_empty", 32'(sbq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
